// File: rtl/cond_sum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_sum_pkg
// Description : Shared helpers for the conditional-sum merge pipeline.
//               Covers the level count, pair-vector bit indexing and the
//               candidate record layout.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_sum_pkg;

  localparam int MAX_WIDTH = 32;

  // Number of merge levels needed to fold WIDTH single-bit blocks into one.
  function automatic int LEVELS_OF(input int width);
    return $clog2(width);
  endfunction

  // Bit positions inside the interleaved {carry,sum} pair vector.
  function automatic int SUM_IDX(input int i);
    return 2 * i;
  endfunction

  function automatic int CAR_IDX(input int i);
    return 2 * i + 1;
  endfunction

  // One candidate block: carry out plus the sum bits. The merge level only
  // uses the low block-width bits of sum; the record is sized for the widest
  // legal operand.
  typedef struct packed {
    logic                 carry;
    logic [MAX_WIDTH-1:0] sum;
  } cand_t;

endpackage
`default_nettype wire

// File: rtl/cond_sum_merge_level.sv
`default_nettype none
// ============================================================================
// Module      : cond_sum_merge_level
// Description : One combinational conditional-sum merge level. Pairs of
//               BLK-wide blocks become 2*BLK-wide blocks, for both the
//               carry-in-0 (A) and carry-in-1 (B) candidates.
// Ports       : i_a / i_b  candidate vectors, blocks of {carry, sum[BLK-1:0]}
//               o_a / o_b  merged vectors, blocks of {carry, sum[2*BLK-1:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module cond_sum_merge_level #(
  parameter int WIDTH = 8,
  parameter int BLK   = 1
) (
  input  logic [WIDTH+WIDTH/BLK-1:0]     i_a,
  input  logic [WIDTH+WIDTH/BLK-1:0]     i_b,
  output logic [WIDTH+WIDTH/(2*BLK)-1:0] o_a,
  output logic [WIDTH+WIDTH/(2*BLK)-1:0] o_b
);

  localparam int NPAIR = WIDTH / (2 * BLK);
  localparam int IW    = BLK + 1;
  localparam int OW    = 2 * BLK + 1;

  for (genvar p = 0; p < NPAIR; p++) begin : g_pair
    logic [IW-1:0] w_alo;
    logic [IW-1:0] w_ahi;
    logic [IW-1:0] w_blo;
    logic [IW-1:0] w_bhi;
    logic [IW-1:0] w_a_sel;
    logic [IW-1:0] w_b_sel;

    assign w_alo = i_a[(2*p)*IW   +: IW];
    assign w_ahi = i_a[(2*p+1)*IW +: IW];
    assign w_blo = i_b[(2*p)*IW   +: IW];
    assign w_bhi = i_b[(2*p+1)*IW +: IW];

    // The low block's carry decides which high-block candidate continues it;
    // the chosen high block's carry becomes the merged carry.
    assign w_a_sel = w_alo[BLK] ? w_bhi : w_ahi;
    assign w_b_sel = w_blo[BLK] ? w_bhi : w_ahi;

    assign o_a[p*OW +: OW] = {w_a_sel, w_alo[BLK-1:0]};
    assign o_b[p*OW +: OW] = {w_b_sel, w_blo[BLK-1:0]};
  end

endmodule
`default_nettype wire

// File: rtl/cond_sum_merge.sv
`default_nettype none
// ============================================================================
// Module      : cond_sum_merge
// Description : Pipelined conditional-sum merge stage. Registers the two
//               per-bit {carry,sum} pair vectors, runs log2(WIDTH) merge
//               levels (one per pipeline stage) and selects the final result
//               with the true carry-in. Whole pipe stalls on backpressure.
// Ports       : clk, rst_n            clock, async active-low reset
//               in_valid / in_ready   upstream handshake
//               r0, r1, cin           pair vectors for cin=0/1, true carry-in
//               out_valid / out_ready downstream handshake
//               sum, cout             registered result
//               txn_count             accepted outputs, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module cond_sum_merge
  import cond_sum_pkg::*;
#(
  parameter int WIDTH = 8,   // power of two, 2..32
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] r0,
  input  logic [2*WIDTH-1:0] r1,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic [CNT_W-1:0]   txn_count
);

  localparam int LEVELS = LEVELS_OF(WIDTH);

  logic             w_adv;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   w_res;

  // Single global enable: bubbles are kept, everything moves together.
  assign w_adv    = out_ready | ~r_out_valid;
  assign in_ready = w_adv;

  // Stage k holds level-k candidates (block width 2^k); stage 0 is the raw
  // pair vectors, which already are width-1 {carry,sum} blocks.
  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int SW = WIDTH + (WIDTH >> k);
    localparam int MW = WIDTH + (WIDTH >> (k + 1));

    logic [SW-1:0] r_a;
    logic [SW-1:0] r_b;
    logic          r_v;
    logic          r_cin;
    logic [SW-1:0] w_na;
    logic [SW-1:0] w_nb;
    logic          w_nv;
    logic          w_ncin;
    logic [MW-1:0] w_ma;
    logic [MW-1:0] w_mb;

    if (k == 0) begin : g_head
      assign w_na   = r0;
      assign w_nb   = r1;
      assign w_nv   = in_valid;  // only sampled while in_ready is high
      assign w_ncin = cin;
    end else begin : g_body
      assign w_na   = g_stage[k-1].w_ma;
      assign w_nb   = g_stage[k-1].w_mb;
      assign w_nv   = g_stage[k-1].r_v;
      assign w_ncin = g_stage[k-1].r_cin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a   <= '0;
        r_b   <= '0;
        r_v   <= 1'b0;
        r_cin <= 1'b0;
      end else if (w_adv) begin
        r_a   <= w_na;
        r_b   <= w_nb;
        r_v   <= w_nv;
        r_cin <= w_ncin;
      end
    end

    cond_sum_merge_level #(
      .WIDTH (WIDTH),
      .BLK   (1 << k)
    ) u_level (
      .i_a (r_a),
      .i_b (r_b),
      .o_a (w_ma),
      .o_b (w_mb)
    );
  end

  // Last level leaves one WIDTH-wide block per candidate: {carry, sum}.
  assign w_res = g_stage[LEVELS-1].r_cin ? g_stage[LEVELS-1].w_mb
                                         : g_stage[LEVELS-1].w_ma;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_adv) begin
        r_out_valid <= g_stage[LEVELS-1].r_v;
        r_sum       <= w_res[WIDTH-1:0];
        r_cout      <= w_res[WIDTH];
      end
      if (r_out_valid && out_ready) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign txn_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cond_sum_merge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_sum_merge
// Description : Self-checking bench for cond_sum_merge (WIDTH=8). Expected
//               results are x+y+cin, queued when an input is accepted and
//               compared when an output is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_sum_merge;
  import cond_sum_pkg::*;

  localparam int W = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2*W-1:0] r0;
  logic [2*W-1:0] r1;
  logic          ci = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sum;
  logic          cout;
  logic [CW-1:0] txn_count;

  logic [W-1:0]  x = '0;
  logic [W-1:0]  y = '0;

  int            checks = 0;
  int            errors = 0;
  int            received = 0;
  logic [W:0]    last_out = '0;
  logic [W:0]    sb[$];

  always #5 clk = ~clk;

  // Per-bit full-adder outputs for carry-in 0 and carry-in 1.
  always_comb begin
    r0 = '0;
    r1 = '0;
    for (int i = 0; i < W; i++) begin
      r0[SUM_IDX(i)] = x[i] ^ y[i];
      r0[CAR_IDX(i)] = x[i] & y[i];
      r1[SUM_IDX(i)] = ~(x[i] ^ y[i]);
      r1[CAR_IDX(i)] = x[i] | y[i];
    end
  end

  cond_sum_merge #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r0        (r0),
    .r1        (r1),
    .cin       (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .txn_count (txn_count)
  );

  // Scoreboard: pop/compare on output handshake, push model on input accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        received++;
        last_out = {cout, sum};
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: unexpected output %h, expected none", {cout, sum});
        end else begin
          logic [W:0] exp_v;
          exp_v = sb.pop_front();
          if ({cout, sum} !== exp_v) begin
            errors++;
            $display("FAIL scoreboard: got %h expected %h", {cout, sum}, exp_v);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci});
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    x = a; y = b; ci = c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (sum !== '0)         begin errors++; $display("FAIL reset_sum: got %h expected 00", sum); end
    if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
    if (txn_count !== '0)   begin errors++; $display("FAIL reset_txn_count: got %0d expected 0", txn_count); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    apply_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    x = 8'h5A; y = 8'h3C; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== (c == 3)) begin
        errors++;
        $display("FAIL latency_valid: cycle %0d got %b expected %b", c, out_valid, (c == 3));
      end
    end
    checks++;
    if ({cout, sum} !== 9'h096) begin
      errors++;
      $display("FAIL latency_result: got %h expected 096", {cout, sum});
    end
    wait_drain();
  endtask

  task automatic test_carry();
    out_ready = 1'b1;
    send_one(8'hFF, 8'h01, 1'b0);
    wait_drain();
    checks++;
    if (last_out !== 9'h100) begin errors++; $display("FAIL carry_ff_01: got %h expected 100", last_out); end
    send_one(8'hFF, 8'h00, 1'b1);
    wait_drain();
    checks++;
    if (last_out !== 9'h100) begin errors++; $display("FAIL carry_ff_00_cin: got %h expected 100", last_out); end
    send_one(8'h00, 8'h00, 1'b1);
    wait_drain();
    checks++;
    if (last_out !== 9'h001) begin errors++; $display("FAIL carry_00_00_cin: got %h expected 001", last_out); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    logic [9:0]   pattern;
    xs = '{8'h01, 8'h80, 8'hAA, 8'h33};
    ys = '{8'h02, 8'h80, 8'h55, 8'h44};
    apply_reset();
    out_ready = 1'b1;
    checks++;
    if (txn_count !== '0) begin errors++; $display("FAIL b2b_count_start: got %0d expected 0", txn_count); end
    pattern = '0;
    x = xs[0]; y = ys[0]; ci = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (c < 3) begin
        x = xs[c+1]; y = ys[c+1]; ci = c[0];
      end else begin
        in_valid = 1'b0;
      end
      pattern[c] = out_valid;
    end
    checks += 2;
    if (pattern !== 10'h078) begin errors++; $display("FAIL b2b_valid_pattern: got %b expected 0001111000", pattern); end
    if (txn_count !== 16'd4) begin errors++; $display("FAIL b2b_count_end: got %0d expected 4", txn_count); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] base;
    base = txn_count;
    out_ready = 1'b0;
    x = 8'h5A; y = 8'h3C; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    x = 8'h12; y = 8'h34; ci = 1'b1;
    @(posedge clk); #1;
    x = 8'h80; y = 8'h80; ci = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    // Offer a new item while stalled; it must not be taken yet.
    x = 8'h7F; y = 8'h01; ci = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (in_ready !== 1'b0)      begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      if (out_valid !== 1'b1)     begin errors++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
      if ({cout, sum} !== 9'h096) begin errors++; $display("FAIL bp_frozen: got %h expected 096", {cout, sum}); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (txn_count !== base + 16'd4) begin
      errors++;
      $display("FAIL bp_count: got %0d expected %0d", txn_count, base + 16'd4);
    end
  endtask

  task automatic test_reset_midflight();
    int spurious;
    out_ready = 1'b1;
    x = 8'h11; y = 8'h22; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    x = 8'h44; y = 8'h55; ci = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
    if (sum !== '0)         begin errors++; $display("FAIL rst_mid_sum: got %h expected 00", sum); end
    if (txn_count !== '0)   begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", txn_count); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL rst_mid_spurious: got %0d valid cycles expected 0", spurious); end
  endtask

  task automatic test_random();
    int  sent;
    int  rcv0;
    int  cyc;
    logic acc;
    sent = 0;
    rcv0 = received;
    in_valid = 1'b0;
    for (cyc = 0; cyc < 40000 && sent < 10000; cyc++) begin
      if (!in_valid) begin
        x = W'($urandom);
        y = W'($urandom);
        ci = 1'($urandom);
        in_valid = ($urandom_range(0, 4) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    checks += 2;
    if (sent != 10000) begin errors++; $display("FAIL rand_sent: got %0d expected 10000", sent); end
    if (received - rcv0 != sent) begin
      errors++;
      $display("FAIL rand_received: got %0d expected %0d", received - rcv0, sent);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cond_sum_merge.md
Name: cond_sum_merge

Overview:
- Pipelined merge stage that sits directly downstream of the per-bit 1-bit full-adder stage in the conditional-sum adder.
- It consumes two copies of that stage's interleaved {carry,sum} pair vector: one computed with carry-in 0, the other with carry-in 1.
- It performs log2(WIDTH) conditional-sum merge levels, one per pipeline stage, then selects the final result with the true carry-in.
- Output is a WIDTH-bit sum and carry-out, with valid/ready handshakes on both sides and a completed-result counter.

Parameters:
- WIDTH, 8, operand width. Must be a power of two, 2..32.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pair vectors and cin are valid.
- in_ready  out  1  stage can accept input this cycle.
- r0  in  2*WIDTH  pair vector for carry-in 0. r0[2i] is the sum of bit i; r0[2i+1] is the carry out of bit i.
- r1  in  2*WIDTH  pair vector for carry-in 1, same layout as r0.
- cin  in  1  true carry-in of the addition.
- out_valid  out  1  sum and cout are valid.
- out_ready  in  1  consumer accepts the output.
- sum  out  WIDTH  final sum.
- cout  out  1  final carry-out.
- txn_count  out  CNT_W  number of accepted outputs, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release on clk): all stage valid bits 0, all stage data 0, out_valid=0, sum=0, cout=0, txn_count=0.
  - in_ready is 1 during and immediately after reset.
- Stage count: LEVELS = log2(WIDTH) register stages. For WIDTH=8 this is 3.
- Latency: an input accepted at clock edge N appears with out_valid=1 after edge N+LEVELS, i.e. 3 cycles for WIDTH=8.
- Global stall: adv = out_ready | ~out_valid, and in_ready = adv.
  - When adv=0, every stage register holds its value, including valid bits and cin.
  - Bubbles are not collapsed.
- Stage-1 valid loads (in_valid & in_ready). Each later valid bit loads its predecessor's valid bit when adv=1.
- Level-0 candidate blocks have width 1:
  - candidate A (carry-in 0) = {r0[2i+1], r0[2i]}.
  - candidate B (carry-in 1) = {r1[2i+1], r1[2i]}.
- Level-k merge combines block pairs of width 2^(k-1) into blocks of width 2^k, for each candidate c:
  - low half = low block's candidate c.
  - high half = high block's candidate A if the low candidate c's carry is 0, else high block's candidate B.
  - merged carry = the selected high block's carry.
- The cin value travels alongside the data through every stage.
- Final stage: the single WIDTH-wide block selects candidate B when the staged cin=1, else candidate A. The result is registered as {cout,sum}.
- Every stage register stores both candidates for all blocks, i.e. 2*(WIDTH+blocks) bits.
- txn_count increments by 1 on each cycle with out_valid & out_ready, wrapping from all-ones to 0.
- out_valid & ~out_ready: sum and cout remain stable until accepted. This is a protocol invariant.
- in_valid with in_ready=0: the input is not captured. The upstream stage must hold it.
- Simultaneous output accept and input accept in the same cycle: full throughput, one result per cycle.
- Reset asserted mid-operation: all in-flight results are discarded immediately and txn_count clears. No spurious out_valid after release.
- Inconsistent r0/r1 (not derived from the same x,y): no error checking. The merge rules are still applied deterministically.

Decomposition:
- Package cond_sum_pkg:
  - LEVELS function (clog2 of WIDTH).
  - Pair-vector index helpers: SUM_IDX(i)=2i, CAR_IDX(i)=2i+1.
  - Candidate record typedef {carry, sum bits} parameterized per level.
- Sub-module cond_sum_merge_level: purely combinational, parameter BLK (input block width).
  - Merges all block pairs of one level for both candidates.
  - Instantiated LEVELS times via generate, with a register after each instance.

Test Plan:
- x=0x5A, y=0x3C, cin=0 (r0 per-bit {x&y, x^y}, r1 per-bit {x|y, ~(x^y)}) -> sum=0x96, cout=0, out_valid 3 cycles after accept.
- x=0xFF, y=0x01, cin=0 -> sum=0x00, cout=1. Then x=0xFF, y=0x00, cin=1 -> sum=0x00, cout=1. Then x=0x00, y=0x00, cin=1 -> sum=0x01, cout=0.
- Back-to-back: 4 vectors on consecutive cycles with out_ready=1 -> 4 results on consecutive cycles starting cycle 3; txn_count goes 0 to 4.
- Backpressure: out_ready=0 with 3 results in flight -> in_ready=0, sum/cout frozen. Release out_ready -> results drain in order with none lost or duplicated.
- Reset mid-flight: drop rst_n asynchronously (between edges) with 2 items in the pipe -> out_valid=0, sum=0, txn_count=0 immediately. After release, no output until new input.
- Exhaustive random compare: 10,000 random x, y, cin with random out_ready -> {cout,sum} == x+y+cin for every accepted result.
